gd_sid_player: RTL and testbench

GD_SID_PLAYER -- requirements
Module: gd_sid_player

---
 rtl/gd_sid_pkg.sv | 31 +++
 rtl/gd_cmd_fifo.sv | 64 ++++++
 rtl/gd_sid_player.sv | 144 ++++++++++++++
 tb/tb_gd_sid_player.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gd_sid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gd_sid_pkg                                                      |
// | Brief    : Shared constants, command field positions and FSM state type    |
// |            for the SID command player.                                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package gd_sid_pkg;

  // Upper 10 address bits of the two SID windows ($D400 and $D420 in 15-bit space)
  localparam logic [9:0] C_SID_BASE0 = 10'b1010100000;
  localparam logic [9:0] C_SID_BASE1 = 10'b1010100001;

  localparam int C_OP_BIT  = 15;
  localparam int C_SEL_BIT = 13;
  localparam int C_IDX_MSB = 12;
  localparam int C_IDX_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_WAIT   = 2'd3
  } sid_state_t;

  function automatic logic [14:0] sid_addr(input logic sel, input logic [4:0] idx);
    return {(sel ? C_SID_BASE1 : C_SID_BASE0), idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gd_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gd_cmd_fifo                                                     |
// | Brief    : Synchronous first-word-fall-through command FIFO with level.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     vga_clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  // Flush discards anything offered or requested in the same cycle
  assign w_push = push && !full  && !flush;
  assign w_pop  = pop  && !empty && !flush;

  always_ff @(posedge vga_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_level == '0);
  assign full    = (r_level == C_FULL_LEVEL);
  assign level   = r_level;

endmodule
`default_nettype wire

// File: rtl/gd_sid_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gd_sid_player                                                   |
// | Brief    : Plays queued SID register writes and tick-based waits onto the  |
// |            SID bus. Define GD_SID_PLAYER_DUAL_EN for dual-SID addressing.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gd_sid_player
  import gd_sid_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TICK_DIV   = 64
) (
  input  logic                          vga_clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [15:0]                   cmd_data,
  input  logic                          flush,
  input  logic                          host_wr,
  output logic                          mem_wr,
  output logic [14:0]                   mem_w_addr,
  output logic [7:0]                    mem_data_wr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);

  sid_state_t  r_state;
  logic [PW-1:0] r_presc;
  logic [14:0] r_wait;
  logic        r_mem_wr;
  logic [14:0] r_addr;
  logic [7:0]  r_data;

  logic [15:0] w_head;
  logic        w_empty;
  logic        w_full;
  logic [LW:0] w_level;
  logic        w_pop;
  logic        w_tick;
  logic        w_sel;
  logic        w_more_after_pop;

  assign w_pop = (r_state == ST_DECODE);

  gd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (cmd_valid),
    .pop     (w_pop),
    .wr_data (cmd_data),
    .rd_data (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .level   (w_level)
  );

`ifdef GD_SID_PLAYER_DUAL_EN
  assign w_sel = w_head[C_SEL_BIT];
`else
  assign w_sel = 1'b0;
`endif

  assign w_tick           = (r_presc == C_PRESC_MAX);
  assign w_more_after_pop = (w_level > (LW+1)'(1));

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // The write strobe is registered, so it appears the cycle after WRITE sees the bus free
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_mem_wr <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_mem_wr <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_wait  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_empty) r_state <= ST_DECODE;
          end
          ST_DECODE: begin
            if (w_empty) begin
              r_state <= ST_IDLE;
            end else if (!w_head[C_OP_BIT]) begin
              r_addr  <= sid_addr(w_sel, w_head[C_IDX_MSB:C_IDX_LSB]);
              r_data  <= w_head[7:0];
              r_state <= ST_WRITE;
            end else if (w_head[14:0] != '0) begin
              r_wait  <= w_head[14:0];
              r_state <= ST_WAIT;
            end else begin
              r_state <= w_more_after_pop ? ST_DECODE : ST_IDLE;
            end
          end
          ST_WRITE: begin
            if (!host_wr) begin
              r_mem_wr <= 1'b1;
              r_state  <= w_empty ? ST_IDLE : ST_DECODE;
            end
          end
          ST_WAIT: begin
            if (r_wait == '0) begin
              r_state <= w_empty ? ST_IDLE : ST_DECODE;
            end else if (w_tick) begin
              r_wait <= r_wait - 15'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready   = !w_full;
  assign mem_wr      = r_mem_wr;
  assign mem_w_addr  = r_addr;
  assign mem_data_wr = r_data;
  assign fifo_level  = w_level;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_gd_sid_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gd_sid_player                                                |
// | Brief    : Scoreboard bench for gd_sid_player with a queue-based model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_gd_sid_player;

  localparam int FIFO_DEPTH = 16;
  localparam int TICK_DIV   = 64;
  localparam int LW         = $clog2(FIFO_DEPTH);

  logic        vga_clk   = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data  = '0;
  logic        flush     = 1'b0;
  logic        host_wr   = 1'b0;
  logic        cmd_ready;
  logic        mem_wr;
  logic [14:0] mem_w_addr;
  logic [7:0]  mem_data_wr;
  logic [LW:0] fifo_level;
  logic        busy;

  gd_sid_player #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .flush       (flush),
    .host_wr     (host_wr),
    .mem_wr      (mem_wr),
    .mem_w_addr  (mem_w_addr),
    .mem_data_wr (mem_data_wr),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    longint      min_gap;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint pend_gap  = 0;
  int     checks    = 0;
  int     failures  = 0;
  longint cyc       = 0;
  longint last_wr   = -1000;
  longint prev_wr   = -1000;
  int     wr_count  = 0;
  logic   prev_host = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference address: SID window at 0x5400, second chip 0x20 above it
  function automatic logic [14:0] model_addr(input logic [15:0] c);
    logic [14:0] a;
    a = 15'h5400 + 15'(c[12:8]);
`ifdef GD_SID_PLAYER_DUAL_EN
    if (c[13]) a = a + 15'h0020;
`endif
    return a;
  endfunction

  function automatic void model_push(input logic [15:0] c);
    exp_t e;
    if (c[15]) begin
      if (c[14:0] > 15'd1) pend_gap += (longint'(c[14:0]) - 1) * TICK_DIV;
    end else begin
      e.addr    = model_addr(c);
      e.data    = c[7:0];
      e.min_gap = 2 + pend_gap;
      pend_gap  = 0;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    pend_gap = 0;
  endfunction

  // Monitor: every strobe must match the oldest expected write
  always @(negedge vga_clk) begin
    cyc = cyc + 1;
    if (mem_wr === 1'b1) begin
      check_cond("wr_after_host_low", prev_host == 1'b0, longint'(prev_host), 0);
      check_cond("wr_expected", exp_q.size() != 0, exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_w_addr), 32'(mon_e.addr));
        check_eq("wr_data", 32'(mem_data_wr), 32'(mon_e.data));
        check_cond("wr_gap", (cyc - last_wr) >= mon_e.min_gap, cyc - last_wr, mon_e.min_gap);
      end
      prev_wr = last_wr;
      last_wr = cyc;
      wr_count++;
    end
    prev_host = host_wr;
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c, output bit acc);
    cmd_valid = 1'b1;
    cmd_data  = c;
    acc       = cmd_ready && !flush;
    tick();
    cmd_valid = 1'b0;
    if (acc) model_push(c);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    flush     = 1'b0;
    host_wr   = 1'b0;
    tick();
    tick();
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < bound)) begin
      tick();
      n++;
    end
    check_cond(name, n < bound, n, bound);
    repeat (3) tick();
  endtask

  task automatic wait_writes(input int target, input int bound, input string name);
    int n;
    n = 0;
    while ((wr_count < target) && (n < bound)) begin
      tick();
      n++;
    end
    check_cond(name, wr_count >= target, wr_count, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    bit          saw;
    int          base;
    longint      diff;
    logic [15:0] c;

    // Reset values while rst_n is held low
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_addr", 32'(mem_w_addr), 32'd0);
    check_eq("rst_data", 32'(mem_data_wr), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);

    // Single write reaches the bus within three cycles
    do_reset();
    base = wr_count;
    send(16'h0418, acc);
    saw = 1'b0;
    for (int i = 0; i < 3 && !saw; i++) begin
      tick();
      if (mem_wr === 1'b1) saw = 1'b1;
    end
    check_cond("single_wr_within3", saw, longint'(saw), 1);
    check_eq("single_wr_addr", 32'(mem_w_addr), 32'h5404);
    check_eq("single_wr_data", 32'(mem_data_wr), 32'h18);
    tick();
    check_eq("single_wr_busy_after", 32'(busy), 32'd0);
    repeat (4) tick();
    check_eq("single_wr_count", 32'(wr_count - base), 32'd1);

    // WRITE, WAIT 3 ticks, WRITE
    do_reset();
    base = wr_count;
    send(16'h0001, acc);
    send(16'h8003, acc);
    send(16'h0102, acc);
    wait_writes(base + 2, 400, "wait_seq_writes");
    diff = last_wr - prev_wr;
    check_cond("wait_spacing", diff >= 129 && diff <= 192, diff, 192);
    wait_idle(50, "wait_seq_idle");

    // Host owns the bus for ten cycles
    host_wr = 1'b1;
    send(16'h0155, acc);
    saw = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mem_wr === 1'b1) saw = 1'b1;
    end
    check_cond("host_hold_no_wr", !saw, longint'(saw), 0);
    host_wr = 1'b0;
    tick();
    check_eq("host_release_wr", 32'(mem_wr), 32'd1);
    wait_idle(50, "host_idle");

    // Fill the FIFO while the player is stalled in WRITE
    host_wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      c = {3'b000, 5'($urandom_range(0, 31)), 8'(i)};
      send(c, acc);
    end
    tick();
    check_eq("full_level", 32'(fifo_level), 32'd16);
    check_eq("full_ready", 32'(cmd_ready), 32'd0);
    send(16'h0AEE, acc);
    check_eq("full_reject", 32'(acc), 32'd0);
    check_eq("full_level_after_reject", 32'(fifo_level), 32'd16);
    host_wr = 1'b0;
    tick();
    host_wr = 1'b1;
    check_eq("full_ready_during_pop", 32'(cmd_ready), 32'd0);
    tick();
    check_eq("level_after_pop", 32'(fifo_level), 32'd15);
    host_wr = 1'b0;
    tick();
    host_wr = 1'b1;
    send(16'h0BCD, acc);
    check_eq("pushpop_accept", 32'(acc), 32'd1);
    check_eq("pushpop_level", 32'(fifo_level), 32'd15);
    host_wr = 1'b0;
    wait_idle(200, "full_drain");

    // Flush during a long wait, with a competing push
    send(16'hFFFF, acc);
    for (int i = 0; i < 5; i++) begin
      c = {3'b000, 5'($urandom_range(0, 31)), 8'($urandom)};
      send(c, acc);
    end
    check_eq("flush_pre_level", 32'(fifo_level), 32'd5);
    flush = 1'b1;
    send(16'h0777, acc);
    flush = 1'b0;
    model_clear();
    check_eq("flush_level", 32'(fifo_level), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd0);
    base = wr_count;
    repeat (100) tick();
    check_eq("flush_no_wr", 32'(wr_count - base), 32'd0);

    // Reset in the middle of a WAIT and of a stalled WRITE
    send(16'h8005, acc);
    send(16'h0011, acc);
    send(16'h0122, acc);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check_eq("rst_wait_level", 32'(fifo_level), 32'd0);
    model_clear();
    rst_n = 1'b1;
    host_wr = 1'b1;
    send(16'h0333, acc);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    model_clear();
    rst_n = 1'b1;
    host_wr = 1'b0;
    base = wr_count;
    repeat (400) tick();
    check_eq("rst_abort_no_wr", 32'(wr_count - base), 32'd0);
    check_eq("rst_abort_busy", 32'(busy), 32'd0);

    // Window select bit
    base = wr_count;
    send(16'h2A55, acc);
    wait_writes(base + 1, 10, "sel_wr_seen");
`ifdef GD_SID_PLAYER_DUAL_EN
    check_eq("sel_addr", 32'(mem_w_addr), 32'h542A);
`else
    check_eq("sel_addr", 32'(mem_w_addr), 32'h540A);
`endif
    wait_idle(20, "sel_idle");

    // Randomized traffic with host collisions and short waits
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) host_wr = ~host_wr;
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 4) == 0) c = {1'b1, 15'($urandom_range(0, 3))};
        else                           c = {1'b0, 15'($urandom)};
        send(c, acc);
      end else begin
        tick();
      end
    end
    host_wr = 1'b0;
    wait_idle(20000, "rand_drain");
    check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
